// File: rtl/ex_hilo_unit_pkg.sv
// Shared definitions for the HI/LO execution unit: operation encodings,
// FSM state encoding, divide iteration count and small op-class helpers.
package ex_hilo_unit_pkg;

  typedef enum logic [2:0] {
    OpNone  = 3'b000,
    OpMult  = 3'b001,
    OpMultu = 3'b010,
    OpDiv   = 3'b011,
    OpDivu  = 3'b100,
    OpMadd  = 3'b101,
    OpMsub  = 3'b110,
    OpRsvd  = 3'b111
  } hiLoOpT;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } hiLoStateT;

  localparam int DivIters  = 32;
  localparam int IterWidth = $clog2(DivIters);

  function automatic logic isMulOp(input logic [2:0] op);
    return (op == OpMult) || (op == OpMultu) || (op == OpMadd) || (op == OpMsub);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/hilo_divider.sv
// Iterative restoring divider on unsigned 32-bit magnitudes.
// Ports:
//   Clk, Reset         clock, asynchronous active-low reset
//   Load               capture Dividend/Divisor and clear the partial remainder
//   Step               commit one quotient bit (StepQuotient/StepRemainder)
//   Dividend, Divisor  operand magnitudes
//   StepQuotient       quotient register after this cycle's step
//   StepRemainder      partial remainder after this cycle's step
// After 32 steps the step outputs of the 32nd cycle are the final results,
// so the caller can register them on the same edge that ends the divide.
module hilo_divider (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic        Step,
  input  logic [31:0] Dividend,
  input  logic [31:0] Divisor,
  output logic [31:0] StepQuotient,
  output logic [31:0] StepRemainder
);

  // quo starts as the dividend; its MSB feeds the remainder each step while
  // quotient bits shift in at the LSB.
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dsr;
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dsr};
    if (!diff[32]) begin
      StepRemainder = diff[31:0];
      StepQuotient  = {quo[30:0], 1'b1};
    end else begin
      // shifted < divisor here, so its top bit is zero and nothing is lost.
      StepRemainder = shifted[31:0];
      StepQuotient  = {quo[30:0], 1'b0};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (Load) begin
      quo <= Dividend;
      rem <= '0;
      dsr <= Divisor;
    end else if (Step) begin
      quo <= StepQuotient;
      rem <= StepRemainder;
    end
  end

endmodule

// File: rtl/ex_hilo_unit.sv
// HI/LO execution unit: multiply, multiply-accumulate and iterative divide.
// Ports:
//   Clk, Reset        clock, asynchronous active-low reset
//   Start, HiLoOp     request and operation code (sampled only in IDLE)
//   A, B              rs / rt operands
//   HiIn, LoIn        current HI/LO, used as the MADD/MSUB accumulator
//   Flush             abort the in-flight operation
//   Busy              high in MUL and DIV; stalls the pipeline
//   Done, HiLoWrite   one-cycle result pulse / HI-LO write enable (same signal)
//   HiOut, LoOut      result, held until the next Done
//   DbgState          current FSM state
// Handshake: a request is taken when Start is high in an IDLE cycle with a
// valid op; Start in any other cycle (MUL, DIV, DONE) is ignored, so the
// upstream stage keeps Start asserted until Busy is seen. Done pulses exactly
// one cycle per completed (unflushed) operation.
module ex_hilo_unit
  import ex_hilo_unit_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  HiLoOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] HiIn,
  input  logic [31:0] LoIn,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic        HiLoWrite,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic [1:0]  DbgState
);

  hiLoStateT            state;
  hiLoOpT               capOp;
  logic [31:0]          capA, capB, capHi, capLo;
  logic                 qNeg, rNeg, divZero;
  logic [IterWidth-1:0] iterCount;

  logic        accept, divLoad, divStep;
  logic [31:0] magA, magB;
  logic [31:0] stepQuo, stepRem;
  logic [31:0] divHi, divLo;
  logic [63:0] sProd, uProd, mulResult;

  assign accept    = (state == StIdle) && Start && (isMulOp(HiLoOp) || isDivOp(HiLoOp));
  assign divLoad   = (state == StIdle) && Start && isDivOp(HiLoOp);
  assign divStep   = (state == StDiv) && !Flush;
  assign HiLoWrite = Done;
  assign DbgState  = state;

  // Only signed DIV takes magnitudes; DIVU passes operands straight through.
  assign magA = (HiLoOp == OpDiv && A[31]) ? -A : A;
  assign magB = (HiLoOp == OpDiv && B[31]) ? -B : B;

  hilo_divider uDivider (
    .Clk           (Clk),
    .Reset         (Reset),
    .Load          (divLoad),
    .Step          (divStep),
    .Dividend      (magA),
    .Divisor       (magB),
    .StepQuotient  (stepQuo),
    .StepRemainder (stepRem)
  );

  // Sign fix-up on the final step outputs. Divide by zero bypasses it so LO
  // is all ones and HI is the raw dividend regardless of signs.
  always_comb begin
    divLo = qNeg ? -stepQuo : stepQuo;
    divHi = rNeg ? -stepRem : stepRem;
    if (divZero) begin
      divLo = '1;
      divHi = capA;
    end
  end

  // 64-bit products keep only the low 64 bits, which is exact for both
  // sign- and zero-extended 32x32 operands; accumulation wraps mod 2^64.
  always_comb begin
    sProd = {{32{capA[31]}}, capA} * {{32{capB[31]}}, capB};
    uProd = {32'b0, capA} * {32'b0, capB};
    case (capOp)
      OpMultu: mulResult = uProd;
      OpMadd:  mulResult = {capHi, capLo} + sProd;
      OpMsub:  mulResult = {capHi, capLo} - sProd;
      default: mulResult = sProd;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= StIdle;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      HiOut     <= '0;
      LoOut     <= '0;
      iterCount <= '0;
      capOp     <= OpNone;
      capA      <= '0;
      capB      <= '0;
      capHi     <= '0;
      capLo     <= '0;
      qNeg      <= 1'b0;
      rNeg      <= 1'b0;
      divZero   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        StIdle: begin
          if (accept) begin
            capOp     <= hiLoOpT'(HiLoOp);
            capA      <= A;
            capB      <= B;
            capHi     <= HiIn;
            capLo     <= LoIn;
            qNeg      <= (HiLoOp == OpDiv) && (A[31] ^ B[31]);
            rNeg      <= (HiLoOp == OpDiv) && A[31];
            divZero   <= (B == '0);
            iterCount <= '0;
            Busy      <= 1'b1;
            state     <= isDivOp(HiLoOp) ? StDiv : StMul;
          end
        end
        StMul: begin
          Busy <= 1'b0;
          if (Flush) begin
            state <= StIdle;
          end else begin
            HiOut <= mulResult[63:32];
            LoOut <= mulResult[31:0];
            Done  <= 1'b1;
            state <= StDone;
          end
        end
        StDiv: begin
          if (Flush) begin
            // Flush also beats the final iteration.
            Busy      <= 1'b0;
            iterCount <= '0;
            state     <= StIdle;
          end else if (iterCount == IterWidth'(DivIters - 1)) begin
            HiOut     <= divHi;
            LoOut     <= divLo;
            Done      <= 1'b1;
            Busy      <= 1'b0;
            iterCount <= '0;
            state     <= StDone;
          end else begin
            iterCount <= iterCount + 1'b1;
          end
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_hilo_unit.sv
module tb_ex_hilo_unit;

  logic        Clk = 1'b0;
  logic        rstN = 1'b0;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [2:0]  HiLoOp = 3'b000;
  logic [31:0] A = '0, B = '0, HiIn = '0, LoIn = '0;
  logic        Busy, Done, HiLoWrite;
  logic [31:0] HiOut, LoOut;
  logic [1:0]  dbgState;

  int checkCount = 0;
  int passCount = 0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  ex_hilo_unit dut (
    .Clk       (Clk),
    .Reset     (rstN),
    .Start     (Start),
    .HiLoOp    (HiLoOp),
    .A         (A),
    .B         (B),
    .HiIn      (HiIn),
    .LoIn      (LoIn),
    .Flush     (Flush),
    .Busy      (Busy),
    .Done      (Done),
    .HiLoWrite (HiLoWrite),
    .HiOut     (HiOut),
    .LoOut     (LoOut),
    .DbgState  (dbgState)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Result arithmetic from the operation definitions; timing as "cycles left".
  function automatic logic [63:0] expectedResult(input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    longint sp;
    longint unsigned up;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    sp = longint'(sa) * longint'(sb);
    up = longint'({32'b0, a}) * longint'({32'b0, b});
    case (op)
      3'd1: return sp;
      3'd2: return up;
      3'd5: return {hi, lo} + sp;
      3'd6: return {hi, lo} - sp;
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  logic [63:0] expQ[$];
  int          remaining = 0;
  bit          mDone = 1'b0;
  bit          prevDone = 1'b0;
  logic [31:0] mHi = '0, mLo = '0;

  always @(posedge Clk or negedge rstN) begin
    if (!rstN) begin
      remaining = 0;
      mDone = 1'b0;
      mHi = '0;
      mLo = '0;
      expQ.delete();
    end else begin
      prevDone = mDone;
      mDone = 1'b0;
      if (remaining > 0) begin
        if (Flush) begin
          remaining = 0;
          void'(expQ.pop_back());
        end else if (remaining == 1) begin
          remaining = 0;
          mDone = 1'b1;
          {mHi, mLo} = expQ.pop_front();
        end else begin
          remaining--;
        end
      end else if (!prevDone && Start && HiLoOp >= 3'd1 && HiLoOp <= 3'd6) begin
        expQ.push_back(expectedResult(HiLoOp, A, B, HiIn, LoIn));
        remaining = (HiLoOp == 3'd3 || HiLoOp == 3'd4) ? 32 : 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge Clk) begin
    check("busy", Busy, (remaining > 0));
    check("done", Done, mDone);
    check("hilowrite", HiLoWrite, mDone);
    check("hiout", HiOut, mHi);
    check("loout", LoOut, mLo);
  end

  // ---------------- driver tasks ----------------
  task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo);
    @(posedge Clk); #1;
    Start = 1'b1; HiLoOp = op; A = a; B = b; HiIn = hi; LoIn = lo;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [31:0] expHi, input logic [31:0] expLo, input int expLat);
    int lat;
    int busyCycles;
    startOp(op, a, b, hi, lo);
    lat = 1;
    busyCycles = 0;
    while (Done !== 1'b1 && lat < 100) begin
      if (Busy === 1'b1) busyCycles++;
      @(posedge Clk); #1;
      lat++;
    end
    check({name, " latency"}, lat, expLat);
    check({name, " busy cycles"}, busyCycles, expLat - 1);
    check({name, " hi"}, HiOut, expHi);
    check({name, " lo"}, LoOut, expLo);
    check({name, " model hi"}, mHi, expHi);
    check({name, " model lo"}, mLo, expLo);
    @(posedge Clk); #1;
  endtask

  task automatic countDones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      if (Done === 1'b1) n++;
      @(posedge Clk); #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int cyc;
    rstN = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset hi", HiOut, 0);
    check("reset lo", LoOut, 0);
    check("reset busy", Busy, 0);
    check("reset done", Done, 0);
    check("reset state", dbgState, 0);
    rstN = 1'b1;

    runOp("mult",     3'd1, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 2);
    runOp("multu",    3'd2, 32'hFFFF_FFFD, 32'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'h6, 32'hFFFF_FFEB, 2);
    runOp("divu",     3'd4, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 33);
    runOp("div neg",  3'd3, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    runOp("div negb", 3'd3, 32'd7, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'd1, 32'hFFFF_FFFD, 33);
    runOp("div zero", 3'd3, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 33);
    runOp("divu zero",3'd4, 32'd5, 32'h0, 32'h0, 32'h0, 32'd5, 32'hFFFF_FFFF, 33);
    runOp("div ovf",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 33);
    runOp("divu big", 3'd4, 32'hFFFF_FFFF, 32'h10, 32'h0, 32'h0, 32'hF, 32'h0FFF_FFFF, 33);
    runOp("madd",     3'd5, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 2);
    runOp("madd neg", 3'd5, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    runOp("msub",     3'd6, 32'd1, 32'd1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    // no-op and reserved codes never go busy
    startOp(3'd0, 32'd3, 32'd3, 32'h0, 32'h0);
    check("none busy", Busy, 0);
    countDones(4, n);
    check("none dones", n, 0);
    startOp(3'd7, 32'd3, 32'd3, 32'h0, 32'h0);
    check("rsvd busy", Busy, 0);
    countDones(4, n);
    check("rsvd dones", n, 0);

    // flush at N+10: Busy low at N+11, no Done, outputs keep msub result
    startOp(3'd4, 32'd100, 32'd7, 32'h0, 32'h0);
    repeat (9) begin @(posedge Clk); #1; end
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("flush busy", Busy, 0);
    countDones(40, n);
    check("flush dones", n, 0);
    check("flush hi kept", HiOut, 32'hFFFF_FFFF);
    check("flush lo kept", LoOut, 32'hFFFF_FFFF);

    // flush coinciding with the final iteration (cycle N+32)
    startOp(3'd4, 32'd9, 32'd2, 32'h0, 32'h0);
    repeat (31) begin @(posedge Clk); #1; end
    check("last iter busy", Busy, 1);
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("last flush busy", Busy, 0);
    countDones(5, n);
    check("last flush dones", n, 0);
    check("last flush lo kept", LoOut, 32'hFFFF_FFFF);

    // flush in IDLE together with Start has no effect
    @(posedge Clk); #1;
    Start = 1'b1; Flush = 1'b1; HiLoOp = 3'd2; A = 32'd2; B = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0; Flush = 1'b0;
    check("idle flush busy", Busy, 1);
    @(posedge Clk); #1;
    check("idle flush done", Done, 1);
    check("idle flush lo", LoOut, 32'd6);

    // flush in the DONE cycle does not cancel the write-back
    startOp(3'd1, 32'd3, 32'd5, 32'h0, 32'h0);
    @(posedge Clk); #1;
    Flush = 1'b1;
    check("done flush done", Done, 1);
    check("done flush lo", LoOut, 32'd15);
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("done flush lo held", LoOut, 32'd15);

    // reset at N+10 of a DIV: outputs clear immediately
    startOp(3'd3, 32'd1000, 32'd3, 32'h0, 32'h0);
    repeat (9) begin @(posedge Clk); #1; end
    #2 rstN = 1'b0;
    #1;
    check("midreset busy", Busy, 0);
    check("midreset done", Done, 0);
    check("midreset hilowrite", HiLoWrite, 0);
    check("midreset hi", HiOut, 0);
    check("midreset lo", LoOut, 0);
    check("midreset state", dbgState, 0);
    @(posedge Clk); #1;
    rstN = 1'b1;
    runOp("divu after reset", 3'd4, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 33);

    // Start held through Busy yields exactly one Done
    @(posedge Clk); #1;
    Start = 1'b1; HiLoOp = 3'd4; A = 32'd50; B = 32'd5;
    cyc = 0;
    n = 0;
    while (Done !== 1'b1 && cyc < 100) begin
      @(posedge Clk); #1;
      cyc++;
    end
    if (Done === 1'b1) n++;
    Start = 1'b0;
    check("held latency", cyc, 33);
    check("held lo", LoOut, 32'd10);
    check("held hi", HiOut, 32'd0);
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done === 1'b1) n++;
    end
    check("held dones", n, 1);

    repeat (2) @(posedge Clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $display("%0d/%0d checks passed", passCount, checkCount + 1);
    $fatal(1);
  end

endmodule

// File: doc/ex_hilo_unit.md
EX_HILO_UNIT -- requirements
Module: ex_hilo_unit

Interface
REQ-001 SHALL have: Clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: Reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: Start  in  1  request; sampled only in IDLE.
REQ-004 SHALL have: HiLoOp  in  3  operation code from ID (ocHiLoOp).
REQ-005 SHALL have: A  in  32  rs operand; B  in  32  rt operand.
REQ-006 SHALL have: HiIn  in  32  and LoIn  in  32, the current HI/LO values from ID.
REQ-007 SHALL have: Flush  in  1  abort the in-flight operation.
REQ-008 SHALL have: Busy  out  1  operation in flight; drives pipeline stall.
REQ-009 SHALL have: Done  out  1  one-cycle result pulse.
REQ-010 SHALL have: HiLoWrite  out  1  HI/LO write-back enable, equal to Done.
REQ-011 SHALL have: HiOut  out  32  and LoOut  out  32, result values held until the next Done.

Function
REQ-012 HiLoOp encoding SHALL be:
- 000 none
- 001 MULT (signed)
- 010 MULTU
- 011 DIV (signed)
- 100 DIVU
- 101 MADD: {HI,LO} += signed A*B
- 110 MSUB: {HI,LO} -= signed A*B
- 111 reserved; treated as none.
REQ-013 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-014 IDLE transitions SHALL be:
- Start with op 001/010/101/110 -> MUL.
- Start with op 011/100 -> DIV.
- Otherwise stay in IDLE.
REQ-015 In the acceptance cycle N, A, B, HiIn, LoIn and HiLoOp SHALL be captured.
REQ-016 MUL SHALL last one cycle and register the 64-bit product plus any accumulate term; DONE follows, so Done asserts at N+2.
REQ-017 DIV SHALL run a 32-iteration restoring divide on operand magnitudes, one quotient bit per cycle (cycles N+1..N+32); DONE follows, so Done asserts at N+33.
REQ-018 Signed DIV SHALL give quotient sign = sign(A) XOR sign(B) and remainder sign = sign(A); LO = quotient, HI = remainder.
REQ-019 Division by zero SHALL give LO = 0xFFFFFFFF and HI = A, with unchanged latency.
REQ-020 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-021 MADD/MSUB SHALL wrap modulo 2^64.
REQ-022 MULT and MULTU SHALL ignore HiIn and LoIn.
REQ-023 Busy SHALL be high exactly in the MUL and DIV states, and SHALL be low in IDLE and DONE.
REQ-024 DONE SHALL return to IDLE next cycle; a Start in the DONE cycle SHALL be ignored, so the upstream stage holds it.
REQ-025 Start while Busy SHALL be ignored.
REQ-026 Flush in MUL or DIV SHALL return the FSM to IDLE next cycle, with no Done and HiOut/LoOut unchanged.
REQ-027 Flush and the final iteration in the same cycle: Flush SHALL win.
REQ-028 Flush in IDLE or DONE SHALL have no effect; a Done already asserted still completes.

Reset
REQ-029 Reset low SHALL immediately force:
- state = IDLE
- Busy = 0, Done = 0, HiLoWrite = 0
- HiOut = 0, LoOut = 0
- iteration counter = 0.
REQ-030 Reset asserted mid-DIV SHALL discard the operation; the first Start after release SHALL behave as from power-up.

Structure
REQ-031 A shared package SHALL define the HiLoOp encodings, the FSM state enum and the DIV iteration count constant (32).
REQ-032 The divider datapath SHALL be one sub-module, hilo_divider (iterative magnitude divide; load/step/quotient/remainder); sign fix-up and the multiplier SHALL stay in ex_hilo_unit.

Verification
REQ-033 MULT A=0xFFFFFFFD, B=7 -> Done at N+2; HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy high for exactly 1 cycle.
REQ-034 DIVU A=100, B=7 -> Done at N+33; LO=14, HI=2. DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 DIV B=0, A=0x12345678 -> LO=0xFFFFFFFF, HI=0x12345678 at N+33. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 MADD HiIn=0, LoIn=0xFFFFFFFF, A=1, B=1 -> HI=1, LO=0. MSUB HiIn=0, LoIn=0, A=1, B=1 -> HI=LO=0xFFFFFFFF.
REQ-037 Start DIV, then at N+10: Flush -> no Done, Busy low at N+11, outputs unchanged. Repeat with Reset low at N+10 -> all outputs 0 at once. Start held during Busy -> exactly one Done.
